// File: rtl/const_bank_pkg.sv
// Shared command encoding for the constant bank and its per-channel cells.
package const_bank_pkg;

   typedef enum logic [2:0] {
      CMD_NONE    = 3'd0,
      CMD_RESTORE = 3'd1,
      CMD_LOCK    = 3'd2,
      CMD_WRITE   = 3'd3,
      CMD_INC     = 3'd4
   } cmd_e;

   // Collapse the four request lines into one command, highest priority first.
   function automatic cmd_e cmd_decode(input logic restore_i, input logic lock_i,
                                       input logic wr_en_i, input logic inc_i);
      cmd_e c;
      if (restore_i)    c = CMD_RESTORE;
      else if (lock_i)  c = CMD_LOCK;
      else if (wr_en_i) c = CMD_WRITE;
      else if (inc_i)   c = CMD_INC;
      else              c = CMD_NONE;
      return c;
   endfunction

endpackage

// File: rtl/const_bank_cell.sv
// One constant channel: value register, lock bit and the next-value mux.
module const_cell
   import const_bank_pkg::*;
#(
   parameter int               WIDTH   = 5,
   parameter logic [WIDTH-1:0] DEFAULT = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  cmd_e             cmd_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   output logic [WIDTH-1:0] value_o,
   output logic             locked_o
);

   logic [WIDTH-1:0] value_q, value_d;
   logic             locked_q, locked_d;

   // Write and increment are silently ignored here when locked; the bank flags the error.
   always_comb begin
      value_d  = value_q;
      locked_d = locked_q;
      if (en_i) begin
         case (cmd_i)
            CMD_RESTORE: begin
               value_d  = DEFAULT;
               locked_d = 1'b0;
            end
            CMD_LOCK:  locked_d = 1'b1;
            CMD_WRITE: if (!locked_q) value_d = wr_data_i;
            CMD_INC:   if (!locked_q) value_d = value_q + WIDTH'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value_q  <= DEFAULT;
         locked_q <= 1'b0;
      end else begin
         value_q  <= value_d;
         locked_q <= locked_d;
      end
   end

   assign value_o  = value_q;
   assign locked_o = locked_q;

endmodule

// File: rtl/const_bank.sv
// Bank of lockable constant channels: command decode, range/lock error detection, err pulse.
module const_bank
   import const_bank_pkg::*;
#(
   parameter int               WIDTH    = 5,
   parameter int               CHANNELS = 4,
   parameter logic [WIDTH-1:0] DEFAULT  = {WIDTH{1'b1}}
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] sel,
   input  logic                                              restore,
   input  logic                                              lock,
   input  logic                                              wr_en,
   input  logic [WIDTH-1:0]                                  wr_data,
   input  logic                                              inc,
   output logic [CHANNELS*WIDTH-1:0]                         value,
   output logic [CHANNELS-1:0]                               locked,
   output logic                                              err
);

   cmd_e                cmd;
   logic [31:0]         sel_ext;
   logic                sel_ok;
   logic [CHANNELS-1:0] sel_hit;
   logic                locked_sel;
   logic                err_q, err_d;

   assign cmd     = cmd_decode(restore, lock, wr_en, inc);
   assign sel_ext = 32'(sel);
   assign sel_ok  = sel_ext < 32'(CHANNELS);

   // Out-of-range selects hit no channel, so they can never modify state.
   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      assign sel_hit[k] = sel_ok && (sel_ext == 32'(k));

      const_cell #(
         .WIDTH   (WIDTH),
         .DEFAULT (DEFAULT)
      ) u_cell (
         .clk       (clk),
         .rst       (rst),
         .cmd_i     (cmd),
         .en_i      (sel_hit[k]),
         .wr_data_i (wr_data),
         .value_o   (value[k*WIDTH +: WIDTH]),
         .locked_o  (locked[k])
      );
   end

   assign locked_sel = |(locked & sel_hit);

   always_comb begin
      err_d = 1'b0;
      if (cmd != CMD_NONE) begin
         if (!sel_ok)
            err_d = 1'b1;
         else if ((cmd == CMD_WRITE || cmd == CMD_INC) && locked_sel)
            err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign err = err_q;

endmodule

// File: tb/tb_const_bank.sv
// Randomized and directed bench for const_bank with a 4-channel and a 3-channel instance.
module tb_const_bank;

   localparam int         W   = 5;
   localparam logic [4:0] DEF = 5'h1F;

   logic        clk;
   logic        rst;
   logic [1:0]  sel;
   logic        restore, lock, wr_en, inc;
   logic [4:0]  wr_data;
   logic [19:0] value4;
   logic [3:0]  locked4;
   logic        err4;
   logic [14:0] value3;
   logic [2:0]  locked3;
   logic        err3;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: index 0 models the 4-channel bank, index 1 the 3-channel bank.
   int mv[2][4];
   bit ml[2][4];
   bit merr[2];

   const_bank #(.WIDTH(W), .CHANNELS(4), .DEFAULT(DEF)) dut4 (
      .clk(clk), .rst(rst), .sel(sel), .restore(restore), .lock(lock),
      .wr_en(wr_en), .wr_data(wr_data), .inc(inc),
      .value(value4), .locked(locked4), .err(err4)
   );

   const_bank #(.WIDTH(W), .CHANNELS(3), .DEFAULT(DEF)) dut3 (
      .clk(clk), .rst(rst), .sel(sel), .restore(restore), .lock(lock),
      .wr_en(wr_en), .wr_data(wr_data), .inc(inc),
      .value(value3), .locked(locked3), .err(err3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < 4; c++) begin
            mv[d][c] = int'(DEF);
            ml[d][c] = 1'b0;
         end
         merr[d] = 1'b0;
      end
   endtask

   task automatic model_step(input int d, input int s, input bit rs, input bit lk,
                             input bit wr, input bit in, input int data);
      int n;
      n = (d == 0) ? 4 : 3;
      merr[d] = 1'b0;
      if (!(rs || lk || wr || in)) return;
      if (s >= n) begin
         merr[d] = 1'b1;
         return;
      end
      if (rs) begin
         mv[d][s] = int'(DEF);
         ml[d][s] = 1'b0;
      end else if (lk) begin
         ml[d][s] = 1'b1;
      end else if (wr) begin
         if (ml[d][s]) merr[d] = 1'b1;
         else          mv[d][s] = data;
      end else begin
         if (ml[d][s]) merr[d] = 1'b1;
         else          mv[d][s] = (mv[d][s] + 1) % 32;
      end
   endtask

   function automatic logic [19:0] exp_value4();
      logic [19:0] v;
      for (int c = 0; c < 4; c++) v[c*5 +: 5] = 5'(mv[0][c]);
      return v;
   endfunction

   function automatic logic [14:0] exp_value3();
      logic [14:0] v;
      for (int c = 0; c < 3; c++) v[c*5 +: 5] = 5'(mv[1][c]);
      return v;
   endfunction

   function automatic logic [3:0] exp_locked4();
      logic [3:0] v;
      for (int c = 0; c < 4; c++) v[c] = ml[0][c];
      return v;
   endfunction

   function automatic logic [2:0] exp_locked3();
      logic [2:0] v;
      for (int c = 0; c < 3; c++) v[c] = ml[1][c];
      return v;
   endfunction

   // Apply one command for one clock edge, advance the model, sample 1 time unit after the edge.
   task automatic drive(input int s, input bit rs, input bit lk, input bit wr,
                        input bit in, input int data);
      sel     = 2'(s);
      restore = rs;
      lock    = lk;
      wr_en   = wr;
      inc     = in;
      wr_data = 5'(data);
      model_step(0, s, rs, lk, wr, in, data);
      model_step(1, s, rs, lk, wr, in, data);
      @(posedge clk);
      #1;
      restore = 1'b0;
      lock    = 1'b0;
      wr_en   = 1'b0;
      inc     = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sel = 2'd0; restore = 1'b0; lock = 1'b0; wr_en = 1'b0; inc = 1'b0; wr_data = 5'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++;
      if (value4 !== 20'hFFFFF) begin
         n_fail++; $display("FAIL reset_value: got %h expected %h", value4, 20'hFFFFF);
      end
      n_checks++;
      if (locked4 !== 4'b0000) begin
         n_fail++; $display("FAIL reset_locked: got %b expected %b", locked4, 4'b0000);
      end
      n_checks++;
      if (err4 !== 1'b0) begin
         n_fail++; $display("FAIL reset_err: got %b expected 0", err4);
      end
      n_checks++;
      if (value3 !== 15'h7FFF) begin
         n_fail++; $display("FAIL reset_value3: got %h expected %h", value3, 15'h7FFF);
      end
   endtask

   task automatic test_write_wrap();
      drive(2, 0, 0, 1, 0, 30);
      n_checks++;
      if (value4[14:10] !== 5'd30) begin
         n_fail++; $display("FAIL write_ch2: got %0d expected 30", value4[14:10]);
      end
      drive(2, 0, 0, 0, 1, 0);
      n_checks++;
      if (value4[14:10] !== 5'd31) begin
         n_fail++; $display("FAIL inc_ch2: got %0d expected 31", value4[14:10]);
      end
      drive(2, 0, 0, 0, 1, 0);
      n_checks++;
      if (value4[14:10] !== 5'd0) begin
         n_fail++; $display("FAIL wrap_ch2: got %0d expected 0", value4[14:10]);
      end
      n_checks++;
      if (err4 !== 1'b0) begin
         n_fail++; $display("FAIL wrap_err: got %b expected 0", err4);
      end
   endtask

   task automatic test_lock();
      drive(1, 0, 1, 0, 0, 0);
      n_checks++;
      if (locked4 !== 4'b0010 || err4 !== 1'b0) begin
         n_fail++; $display("FAIL lock_set: got locked=%b err=%b expected 0010/0", locked4, err4);
      end
      drive(1, 0, 0, 1, 0, 3);
      n_checks++;
      if (value4[9:5] !== 5'd31) begin
         n_fail++; $display("FAIL lock_hold: got %0d expected 31", value4[9:5]);
      end
      n_checks++;
      if (err4 !== 1'b1) begin
         n_fail++; $display("FAIL lock_err: got %b expected 1", err4);
      end
      n_checks++;
      if (locked4 !== 4'b0010) begin
         n_fail++; $display("FAIL lock_bits: got %b expected 0010", locked4);
      end
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (err4 !== 1'b0) begin
         n_fail++; $display("FAIL lock_err_one_cycle: got %b expected 0", err4);
      end
   endtask

   task automatic test_priority_restore();
      drive(1, 1, 0, 1, 0, 3);
      n_checks++;
      if (value4[9:5] !== 5'd31 || locked4 !== 4'b0000 || err4 !== 1'b0) begin
         n_fail++;
         $display("FAIL restore_prio: got v=%0d locked=%b err=%b expected 31/0000/0",
                  value4[9:5], locked4, err4);
      end
   endtask

   task automatic test_range();
      logic [14:0] before3;
      before3 = value3;
      drive(3, 0, 0, 1, 0, 4);
      n_checks++;
      if (value3 !== before3) begin
         n_fail++; $display("FAIL range_value: got %h expected %h", value3, before3);
      end
      n_checks++;
      if (err3 !== 1'b1) begin
         n_fail++; $display("FAIL range_err: got %b expected 1", err3);
      end
      n_checks++;
      if (value4[19:15] !== 5'd4) begin
         n_fail++; $display("FAIL range_ch3_in4: got %0d expected 4", value4[19:15]);
      end
      drive(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (err3 !== 1'b0) begin
         n_fail++; $display("FAIL range_err_once: got %b expected 0", err3);
      end
   endtask

   task automatic test_async_reset();
      drive(0, 0, 0, 1, 0, 7);
      n_checks++;
      if (value4[4:0] !== 5'd7) begin
         n_fail++; $display("FAIL async_pre_write: got %0d expected 7", value4[4:0]);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (value4 !== 20'hFFFFF || locked4 !== 4'b0000 || err4 !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got v=%h locked=%b err=%b expected FFFFF/0000/0",
                  value4, locked4, err4);
      end
      // A command presented while rst is held must be dropped without a later err.
      sel = 2'd3; wr_en = 1'b1; wr_data = 5'd5;
      @(posedge clk);
      #1;
      model_reset();
      rst = 1'b0;
      n_checks++;
      if (value4 !== 20'hFFFFF || value3 !== 15'h7FFF) begin
         n_fail++; $display("FAIL reset_cmd_drop: got %h/%h expected FFFFF/7FFF", value4, value3);
      end
      drive(0, 0, 0, 1, 0, 9);
      n_checks++;
      if (value4[4:0] !== 5'd9 || err4 !== 1'b0 || err3 !== 1'b0) begin
         n_fail++;
         $display("FAIL first_edge_cmd: got v=%0d err4=%b err3=%b expected 9/0/0",
                  value4[4:0], err4, err3);
      end
   endtask

   task automatic test_random();
      int s, data;
      bit rs, lk, wr, in;
      for (int i = 0; i < 400; i++) begin
         s    = int'($urandom_range(0, 3));
         rs   = ($urandom_range(0, 9) == 0);
         lk   = ($urandom_range(0, 7) == 0);
         wr   = ($urandom_range(0, 2) == 0);
         in   = ($urandom_range(0, 2) == 0);
         data = int'($urandom_range(0, 31));
         drive(s, rs, lk, wr, in, data);
         n_checks++;
         if (value4 !== exp_value4()) begin
            n_fail++; $display("FAIL rand_value4 cyc %0d: got %h expected %h", i, value4, exp_value4());
         end
         n_checks++;
         if (locked4 !== exp_locked4()) begin
            n_fail++; $display("FAIL rand_locked4 cyc %0d: got %b expected %b", i, locked4, exp_locked4());
         end
         n_checks++;
         if (err4 !== merr[0]) begin
            n_fail++; $display("FAIL rand_err4 cyc %0d: got %b expected %b", i, err4, merr[0]);
         end
         n_checks++;
         if (value3 !== exp_value3()) begin
            n_fail++; $display("FAIL rand_value3 cyc %0d: got %h expected %h", i, value3, exp_value3());
         end
         n_checks++;
         if (locked3 !== exp_locked3()) begin
            n_fail++; $display("FAIL rand_locked3 cyc %0d: got %b expected %b", i, locked3, exp_locked3());
         end
         n_checks++;
         if (err3 !== merr[1]) begin
            n_fail++; $display("FAIL rand_err3 cyc %0d: got %b expected %b", i, err3, merr[1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_wrap();
      test_lock();
      test_priority_restore();
      test_range();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/const_bank.md
CONST_BANK -- requirements
Module: const_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 5, giving the bit width of each constant channel.
REQ-002 SHALL have parameter CHANNELS, default 4, giving the number of independent constant channels (range 1..32).
REQ-003 SHALL have parameter DEFAULT, default {WIDTH{1'b1}}, giving the reset and restore value of every channel.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port sel, input, max(1,$clog2(CHANNELS)) bits: the channel targeted by this cycle's command.
REQ-007 SHALL have port restore, input, 1 bit: reload the selected channel with DEFAULT and unlock it.
REQ-008 SHALL have port lock, input, 1 bit: set the lock bit of the selected channel.
REQ-009 SHALL have port wr_en, input, 1 bit: write wr_data into the selected channel.
REQ-010 SHALL have port wr_data, input, WIDTH bits: the write value.
REQ-011 SHALL have port inc, input, 1 bit: increment the selected channel by 1, modulo 2^WIDTH.
REQ-012 SHALL have port value, output, CHANNELS*WIDTH bits: the registered channel values, channel k at bits [k*WIDTH +: WIDTH].
REQ-013 SHALL have port locked, output, CHANNELS bits: the registered per-channel lock bits.
REQ-014 SHALL have port err, output, 1 bit: a registered one-cycle pulse flagging a rejected command.

Function
REQ-015 SHALL evaluate exactly one command per cycle, in priority order restore > lock > wr_en > inc; lower-priority commands asserted in the same cycle are discarded without error.
REQ-016 SHALL, on restore, set the selected channel's value to DEFAULT and clear its lock bit at the next edge, regardless of the lock state.
REQ-017 SHALL, on lock, set the selected channel's lock bit and leave its value unchanged; locking an already locked channel is a no-op with no error.
REQ-018 SHALL, on wr_en to an unlocked channel, load wr_data at the next edge, visible on value after 1 cycle of latency.
REQ-019 SHALL, on inc to an unlocked channel, load value+1 truncated to WIDTH bits, so all-ones wraps to 0.
REQ-020 SHALL, on wr_en or inc to a locked channel, leave all state unchanged and assert err for exactly the following cycle.
REQ-021 SHALL, when sel >= CHANNELS and any command is asserted, change no state and assert err for the following cycle.
REQ-022 SHALL keep err at 0 in every cycle that does not follow a rejected command.
REQ-023 SHALL leave every non-selected channel unchanged in every cycle.

Reset
REQ-024 SHALL, while rst is high, force every channel to DEFAULT, every locked bit to 0 and err to 0, without waiting for a clock edge.
REQ-025 SHALL, when rst is asserted in the same cycle as a command, discard that command with no err pulse after rst is released.
REQ-026 SHALL accept a command on the first rising edge after rst is released.

Structure
REQ-027 SHALL place the command priority encoding constants (CMD_NONE, CMD_RESTORE, CMD_LOCK, CMD_WRITE, CMD_INC) in the shared package const_bank_pkg.
REQ-028 SHALL implement each channel as one instance of sub-module const_cell (value register, lock bit, next-value mux), generated CHANNELS times.
REQ-029 SHALL perform decode, error detection and the err register in const_bank itself.

Verification
REQ-030 SHALL test reset: after rst is released with defaults, value = 20'hFFFFF, locked = 4'b0000 and err = 0.
REQ-031 SHALL test write then wrap: wr_en sel=2 wr_data=5'd30, then inc twice; channel 2 reads 30, then 31, then 0.
REQ-032 SHALL test lock: lock sel=1, then wr_en sel=1 wr_data=5'd3; channel 1 stays 31, err pulses for 1 cycle, locked = 4'b0010.
REQ-033 SHALL test priority and restore: restore+wr_en sel=1 in one cycle; channel 1 = 31, locked = 4'b0000, no err.
REQ-034 SHALL test range check: with CHANNELS=3, wr_en sel=3; no channel changes and err pulses once.
REQ-035 SHALL test asynchronous reset mid-operation: assert rst between edges after channel 0 has been written 5'd7; value returns to all-ones before the next edge.
